// File: rtl/hex_scan_ctrl_pkg.sv
// Shared types and constants for the multiplexed four-digit hex display scanner.
package hex_scan_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_BLANK = 2'd2
  } state_t;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [3:0] DIG_OFF   = 4'hF;

  // Active-low segments, bit0=a .. bit6=g; entry n is the pattern for hex digit n.
  localparam logic [0:15][6:0] SEG_TABLE = {
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

endpackage

// File: rtl/hex_scan_ctrl_if.sv
// Load handshake and display pin bundle of the hex scanner.
interface hex_scan_ctrl_if;
  logic        ENABLE;
  logic        LOAD_VALID;
  logic [15:0] LOAD_VALUE;
  logic        LOAD_READY;
  logic [6:0]  HEX_SEG;
  logic [3:0]  DIG_EN;
  logic        FRAME_TICK;

  modport master (
    output ENABLE, LOAD_VALID, LOAD_VALUE,
    input  LOAD_READY, HEX_SEG, DIG_EN, FRAME_TICK
  );

  modport slave (
    input  ENABLE, LOAD_VALID, LOAD_VALUE,
    output LOAD_READY, HEX_SEG, DIG_EN, FRAME_TICK
  );
endinterface

// File: rtl/hex_scan_ctrl_seg7_hex_lut.sv
// Combinational hex nibble to active-low seven-segment decode, shared by all digits.
module seg7_hex_lut
  import hex_scan_ctrl_pkg::*;
(
  input  logic [3:0] nib,
  output logic [6:0] seg
);

  assign seg = SEG_TABLE[nib];

endmodule

// File: rtl/hex_scan_ctrl.sv
// Four-digit multiplexed hex display scanner with tear-free shadow loading.
// Optional build macro HEX_SCAN_LZ_BLANK_EN suppresses leading zero digits.
//
// state    | meaning
// ST_IDLE  | scanning stopped, pins blank, idx and prescaler held at 0
// ST_DRIVE | digit idx driven for CLK_DIV cycles
// ST_BLANK | all digits off for BLANK_CYC cycles before the next digit
module hex_scan_ctrl
  import hex_scan_ctrl_pkg::*;
#(
  parameter int CLK_DIV   = 50000,
  parameter int BLANK_CYC = 16
) (
  input  logic           CLOCK_50,
  input  logic           RST,
  hex_scan_ctrl_if.slave bus
);

  localparam int CNT_W = 20;
  localparam logic [CNT_W-1:0] DRIVE_LOAD = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] BLANK_LOAD = CNT_W'(BLANK_CYC - 1);

  state_t           state, state_nxt;
  logic [1:0]       idx, idx_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             wrap;

  logic [15:0] display, shadow;
  logic        pending;
  logic        accept;

  logic [3:0] cur_nib;
  logic [6:0] cur_seg;
  logic       hidden;

  logic [6:0] hex_seg_q;
  logic [3:0] dig_en_q;
  logic       frame_tick_q;

  always_ff @(posedge CLOCK_50 or posedge RST) begin
    if (RST) begin
      state <= ST_IDLE;
      idx   <= 2'd0;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    cnt_nxt   = cnt;
    wrap      = 1'b0;
    case (state)
      ST_IDLE: begin
        idx_nxt = 2'd0;
        cnt_nxt = '0;
        if (bus.ENABLE) begin
          state_nxt = ST_DRIVE;
          cnt_nxt   = DRIVE_LOAD;
        end
      end
      ST_DRIVE: begin
        if (!bus.ENABLE) begin
          state_nxt = ST_IDLE;
          idx_nxt   = 2'd0;
          cnt_nxt   = '0;
        end else if (cnt == '0) begin
          state_nxt = ST_BLANK;
          cnt_nxt   = BLANK_LOAD;
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end
      ST_BLANK: begin
        if (!bus.ENABLE) begin
          state_nxt = ST_IDLE;
          idx_nxt   = 2'd0;
          cnt_nxt   = '0;
        end else if (cnt == '0) begin
          state_nxt = ST_DRIVE;
          idx_nxt   = idx + 2'd1;
          cnt_nxt   = DRIVE_LOAD;
          wrap      = (idx == 2'd3);
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        idx_nxt   = 2'd0;
        cnt_nxt   = '0;
      end
    endcase
  end

  // Acceptance needs pending=0 and the wrap copy needs pending=1, so they never collide.
  assign accept         = bus.LOAD_VALID & ~pending;
  assign bus.LOAD_READY = ~pending;

  assign cur_nib = display[{idx, 2'b00} +: 4];

  seg7_hex_lut u_lut (
    .nib (cur_nib),
    .seg (cur_seg)
  );

`ifdef HEX_SCAN_LZ_BLANK_EN
  logic lead3, lead2, lead1;
  assign lead3 = (display[15:12] == 4'h0);
  assign lead2 = lead3 & (display[11:8] == 4'h0);
  assign lead1 = lead2 & (display[7:4] == 4'h0);
  always_comb begin
    hidden = 1'b0;
    case (idx)
      2'd3:    hidden = lead3;
      2'd2:    hidden = lead2;
      2'd1:    hidden = lead1;
      default: hidden = 1'b0;
    endcase
  end
`else
  assign hidden = 1'b0;
`endif

  always_ff @(posedge CLOCK_50 or posedge RST) begin
    if (RST) begin
      display      <= 16'h0000;
      shadow       <= 16'h0000;
      pending      <= 1'b0;
      hex_seg_q    <= SEG_BLANK;
      dig_en_q     <= DIG_OFF;
      frame_tick_q <= 1'b0;
    end else begin
      if (accept) begin
        shadow  <= bus.LOAD_VALUE;
        pending <= 1'b1;
      end else if (wrap && pending) begin
        display <= shadow;
        pending <= 1'b0;
      end
      frame_tick_q <= wrap;
      if (state == ST_DRIVE && !hidden) begin
        dig_en_q  <= ~(4'b0001 << idx);
        hex_seg_q <= cur_seg;
      end else begin
        dig_en_q  <= DIG_OFF;
        hex_seg_q <= SEG_BLANK;
      end
    end
  end

  assign bus.HEX_SEG    = hex_seg_q;
  assign bus.DIG_EN     = dig_en_q;
  assign bus.FRAME_TICK = frame_tick_q;

endmodule

// File: tb/tb_hex_scan_ctrl.sv
// Directed self-checking bench for hex_scan_ctrl with CLK_DIV=4, BLANK_CYC=2.
module tb_hex_scan_ctrl;

  localparam int CLK_DIV   = 4;
  localparam int BLANK_CYC = 2;
`ifdef HEX_SCAN_LZ_BLANK_EN
  localparam bit LZ = 1'b1;
`else
  localparam bit LZ = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  hex_scan_ctrl_if bus ();

  hex_scan_ctrl #(.CLK_DIV(CLK_DIV), .BLANK_CYC(BLANK_CYC)) dut (
    .CLOCK_50 (clk),
    .RST      (rst),
    .bus      (bus.slave)
  );

  int total  = 0;
  int passed = 0;
  int failed = 0;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [6:0] seg_of(input logic [3:0] n);
    case (n)
      4'h0: return 7'h40;  4'h1: return 7'h79;  4'h2: return 7'h24;  4'h3: return 7'h30;
      4'h4: return 7'h19;  4'h5: return 7'h12;  4'h6: return 7'h02;  4'h7: return 7'h78;
      4'h8: return 7'h00;  4'h9: return 7'h10;  4'hA: return 7'h08;  4'hB: return 7'h03;
      4'hC: return 7'h46;  4'hD: return 7'h21;  4'hE: return 7'h06;  default: return 7'h0E;
    endcase
  endfunction

  function automatic bit hidden_digit(input logic [15:0] v, input int k);
    if (!LZ || k == 0) return 1'b0;
    for (int j = k; j < 4; j++)
      if (v[j*4 +: 4] != 4'h0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_blank(input string tag);
    chk({tag, "_dig"}, {12'h0, bus.DIG_EN}, 16'h000F);
    chk({tag, "_seg"}, {9'h0, bus.HEX_SEG}, 16'h007F);
  endtask

  // One digit slot: CLK_DIV driven cycles then BLANK_CYC blank cycles.
  task automatic check_slot(input int k, input logic [3:0] dig, input logic [6:0] seg, input bit rdy);
    for (int i = 0; i < CLK_DIV; i++) begin
      tick();
      chk($sformatf("d%0d_c%0d_dig", k, i), {12'h0, bus.DIG_EN}, {12'h0, dig});
      chk($sformatf("d%0d_c%0d_seg", k, i), {9'h0, bus.HEX_SEG}, {9'h0, seg});
      chk($sformatf("d%0d_c%0d_rdy", k, i), {15'h0, bus.LOAD_READY}, {15'h0, rdy});
      chk($sformatf("d%0d_c%0d_tick", k, i), {15'h0, bus.FRAME_TICK}, 16'h0);
    end
    for (int i = 0; i < BLANK_CYC; i++) begin
      tick();
      chk_blank($sformatf("d%0d_b%0d", k, i));
      chk($sformatf("d%0d_b%0d_tick", k, i), {15'h0, bus.FRAME_TICK},
          {15'h0, (k == 3 && i == BLANK_CYC - 1)});
    end
  endtask

  task automatic check_frame(input logic [15:0] v, input bit rdy);
    for (int k = 0; k < 4; k++) begin
      if (hidden_digit(v, k)) check_slot(k, 4'hF, 7'h7F, rdy);
      else check_slot(k, ~(4'b0001 << k), seg_of(v[k*4 +: 4]), rdy);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.ENABLE     = 1'b0;
    bus.LOAD_VALID = 1'b0;
    bus.LOAD_VALUE = 16'h0000;

    #12;
    chk_blank("in_reset");
    chk("in_reset_rdy", {15'h0, bus.LOAD_READY}, 16'h1);
    chk("in_reset_tick", {15'h0, bus.FRAME_TICK}, 16'h0);
    @(posedge clk); #1 rst = 1'b0;

    for (int i = 0; i < 10; i++) begin
      tick();
      chk_blank($sformatf("idle%0d", i));
      chk($sformatf("idle%0d_rdy", i), {15'h0, bus.LOAD_READY}, 16'h1);
    end

    // Load in IDLE, stays pending through the first frame.
    bus.LOAD_VALID = 1'b1; bus.LOAD_VALUE = 16'h12AF;
    tick();
    bus.LOAD_VALID = 1'b0;
    chk("load_idle_rdy", {15'h0, bus.LOAD_READY}, 16'h0);
    bus.ENABLE = 1'b1;
    tick();
    chk_blank("enter_drive");
    check_frame(16'h0000, 1'b0);
    chk("wrap1_rdy", {15'h0, bus.LOAD_READY}, 16'h1);
    check_frame(16'h12AF, 1'b1);

    // Mid-frame load of 0000 during digit 1, then a held-off second offer.
    check_slot(0, 4'hE, 7'h0E, 1'b1);
    bus.LOAD_VALID = 1'b1; bus.LOAD_VALUE = 16'h0000;
    check_slot(1, 4'hD, 7'h08, 1'b0);
    bus.LOAD_VALUE = 16'h8888;
    check_slot(2, 4'hB, 7'h24, 1'b0);
    check_slot(3, 4'h7, 7'h79, 1'b0);
    chk("wrap_mid_rdy", {15'h0, bus.LOAD_READY}, 16'h1);
    check_frame(16'h0000, 1'b0);
    bus.LOAD_VALID = 1'b0;

    // ENABLE dropped in the digit-2 slot.
    check_slot(0, 4'hE, 7'h00, 1'b1);
    check_slot(1, 4'hD, 7'h00, 1'b1);
    tick();
    chk("d2_before_drop", {12'h0, bus.DIG_EN}, 16'h000B);
    bus.ENABLE = 1'b0;
    tick();
    tick();
    chk_blank("after_drop");
    chk("after_drop_tick", {15'h0, bus.FRAME_TICK}, 16'h0);
    tick();
    chk_blank("idle_after_drop");
    bus.ENABLE = 1'b1;
    tick();
    chk_blank("reenable_edge");
    tick();
    chk("restart_dig", {12'h0, bus.DIG_EN}, 16'h000E);
    chk("restart_seg", {9'h0, bus.HEX_SEG}, 16'h0000);

    // Pending value, then RST during BLANK.
    bus.LOAD_VALID = 1'b1; bus.LOAD_VALUE = 16'h1234;
    tick();
    bus.LOAD_VALID = 1'b0;
    chk("pend_1234_rdy", {15'h0, bus.LOAD_READY}, 16'h0);
    tick(); tick(); tick();
    chk_blank("in_blank");
    #2 rst = 1'b1;
    #1;
    chk("rst_blank_rdy", {15'h0, bus.LOAD_READY}, 16'h1);
    chk_blank("rst_blank");
    chk("rst_blank_tick", {15'h0, bus.FRAME_TICK}, 16'h0);
    bus.ENABLE = 1'b0;
    tick(); tick();
    rst = 1'b0;

    // Display cleared by reset; async blank from DRIVE.
    bus.ENABLE = 1'b1;
    tick(); tick();
    chk("post_rst_dig", {12'h0, bus.DIG_EN}, 16'h000E);
    chk("post_rst_seg", {9'h0, bus.HEX_SEG}, 16'h0040);
    #2 rst = 1'b1;
    #1;
    chk_blank("rst_drive");
    bus.ENABLE = 1'b0;
    tick();
    rst = 1'b0;

    // Value with leading zeros, loaded in IDLE.
    bus.LOAD_VALID = 1'b1; bus.LOAD_VALUE = 16'h0050;
    tick();
    bus.LOAD_VALID = 1'b0;
    chk("pend_0050_rdy", {15'h0, bus.LOAD_READY}, 16'h0);
    bus.ENABLE = 1'b1;
    tick();
    chk_blank("enter_drive2");
    check_frame(16'h0000, 1'b0);
    chk("wrap_0050_rdy", {15'h0, bus.LOAD_READY}, 16'h1);
    check_frame(16'h0050, 1'b1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/hex_scan_ctrl.md
HEX_SCAN_CTRL -- requirements
Module: hex_scan_ctrl

Interface
REQ-001 Parameter CLK_DIV, default 50000: number of clock cycles each digit is driven; legal range 2..2^20.
REQ-002 Parameter BLANK_CYC, default 16: number of inter-digit blanking cycles that prevent ghosting; legal range 1..255.
REQ-003 Port CLOCK_50, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 Port RST, input, 1 bit: asynchronous, active-high reset.
REQ-005 Port ENABLE, input, 1 bit: scanning enable.
REQ-006 Port LOAD_VALID, input, 1 bit: LOAD_VALUE offered.
REQ-007 Port LOAD_VALUE, input, 16 bits: four hex nibbles; digit k displays [4k+3:4k].
REQ-008 Port LOAD_READY, output, 1 bit: shadow register empty, so the block can accept LOAD_VALUE.
REQ-009 Port HEX_SEG, output, 7 bits: shared segment bus, active-low; bit0=a ... bit6=g.
REQ-010 Port DIG_EN, output, 4 bits: digit selects, active-low, at most one low at a time.
REQ-011 Port FRAME_TICK, output, 1 bit: one-cycle pulse on every digit-3-to-0 wrap.

Function
REQ-012 The FSM SHALL have three states (IDLE, DRIVE, BLANK) plus a 2-bit digit index, a prescaler, a display register and a shadow register with a pending flag.
- IDLE -> DRIVE (digit 0): on the first edge with ENABLE=1.
- DRIVE -> BLANK: after CLK_DIV cycles in DRIVE.
- BLANK -> DRIVE: after BLANK_CYC cycles, with the digit index incremented mod 4.
REQ-013 ENABLE=0 in DRIVE or BLANK SHALL force IDLE on the next edge, resetting the digit index to 0 and the prescaler to 0; the display and shadow contents are kept.
REQ-014 In DRIVE, DIG_EN[idx] SHALL be 0 and HEX_SEG SHALL be the decoded nibble for idx; in IDLE and BLANK, DIG_EN=4'hF and HEX_SEG=7'h7F.
REQ-015 All outputs SHALL be registered: pins reflect the state one cycle after it is entered.
REQ-016 Decode SHALL be standard hex, active-low (0=7'h40, 1=7'h79, 8=7'h00, A=7'h08, F=7'h0E).
REQ-017 Handshake: a value is accepted on an edge where LOAD_VALID=1 and LOAD_READY=1.
- Accepted value -> shadow register; pending=1.
- LOAD_READY = ~pending, combinational from the flag.
REQ-018 On a BLANK-to-DRIVE transition from digit 3 to digit 0 with pending=1:
- display <= shadow; pending <= 0.
- Updates therefore never tear mid-frame.
REQ-019 Acceptance and the wrap SHALL NOT coincide, because LOAD_READY=0 whenever pending=1; an offer during that cycle waits.
REQ-020 FRAME_TICK SHALL pulse in the cycle after every digit-3-to-0 wrap, including wraps with no pending update.
REQ-021 A value loaded while in IDLE SHALL stay pending until the first wrap after scanning starts.

Reset
REQ-022 On RST (asynchronous) the block SHALL set:
- state IDLE, idx 0, prescaler 0;
- display 16'h0000, pending 0 (LOAD_READY=1);
- HEX_SEG 7'h7F, DIG_EN 4'hF, FRAME_TICK 0.
REQ-023 RST mid-frame SHALL blank the outputs immediately and discard any pending value.

Configuration
REQ-024 With macro HEX_SCAN_LZ_BLANK_EN defined, leading zero digits (from digit 3 downward, stopping at the first nonzero digit) SHALL have DIG_EN held high during their DRIVE slot; digit 0 is always shown.
REQ-025 With HEX_SCAN_LZ_BLANK_EN undefined, all four digits SHALL always be shown; the slot timing is identical in both builds.

Structure
REQ-026 A shared package SHALL hold:
- the FSM state typedef;
- the segment constants SEG_BLANK=7'h7F and DIG_OFF=4'hF;
- the 16-entry hex-to-segment constant table.
REQ-027 The decode SHALL sit in one sub-module, seg7_hex_lut (4-bit in, 7-bit active-low out, purely combinational), instantiated once and shared by all digits.

Verification
REQ-028 The bench SHALL use CLK_DIV=4 and BLANK_CYC=2 and cover:
- Reset release, ENABLE=0 for 10 cycles -> HEX_SEG=7'h7F, DIG_EN=4'hF, LOAD_READY=1 throughout.
- Load 16'h12AF, ENABLE=1 -> after the first wrap the pins cycle DIG_EN 4'hE/HEX_SEG 7'h0E, 4'hD/7'h08, 4'hB/7'h24, 4'h7/7'h79; each slot is 4 cycles followed by 2 blank cycles.
- Mid-frame load of 16'h0000 -> LOAD_READY=0 until the wrap; the display changes only at digit 0; a second offer during pending is held off.
- ENABLE dropped during the digit-2 DRIVE slot -> blank on the next edge; re-enable restarts at digit 0.
- RST asserted during BLANK with pending=1 -> outputs blank asynchronously, LOAD_READY=1, display=0.
- HEX_SCAN_LZ_BLANK_EN build, value 16'h0050 -> digits 3 and 2 never enabled, digit 1 shows 7'h12, digit 0 shows 7'h40.
